// File: rtl/usb_tx_serializer.sv
// USB low-level transmit serializer: one-byte buffer, SYNC, NRZI, EOP.
// Optional bit stuffing is compiled in when USB_TX_BIT_STUFF_EN is defined.
module usb_tx_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_en,
  input  logic [7:0] tx_to_data,
  input  logic       tx_to_sop,
  input  logic       tx_to_eop,
  input  logic       tx_to_valid,
  output logic       tx_to_ready,
  output logic       usb_dp,
  output logic       usb_dn,
  output logic       usb_oe,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic [2:0] dbg_state_o
);

  // Handshake: a byte transfers on any clk edge where tx_to_valid && tx_to_ready.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_DATA    = 3'd2,
    S_EOP_SE0 = 3'd3,
    S_EOP_J   = 3'd4
  } state_e;

  state_e     state_q;
  logic       buf_full_q;
  logic [7:0] buf_data_q;
  logic       buf_sop_q;
  logic       buf_eop_q;
  logic [7:0] shift_q;
  logic       cur_eop_q;
  logic [2:0] bit_cnt_q;
  logic       line_j_q;
  logic       done_q;
  logic       dp_q;
  logic       dn_q;
  logic       oe_q;
  logic       underrun_q;

  logic       accept;
  logic       keep_byte;
  logic       start;
  logic       idle_drop;
  logic       sync_last;
  logic       byte_end;
  logic       load;
  logic       raw_bit;
  logic       line_d;
  logic       stuff_now;
  logic       stuff_after_last;

  always_comb begin
    accept    = tx_to_valid & ~buf_full_q;
    keep_byte = accept & ~((state_q == S_IDLE) & ~tx_to_sop);
    start     = (state_q == S_IDLE) &
                ((accept & tx_to_sop) | (buf_full_q & buf_sop_q));
    idle_drop = (state_q == S_IDLE) & buf_full_q & ~buf_sop_q;
    sync_last = (bit_cnt_q == 3'd7);
    byte_end  = bit_en & (state_q == S_DATA) & ~stuff_now & (bit_cnt_q == 3'd7);
    load      = bit_en & (((state_q == S_SYNC) & sync_last) |
                          (byte_end & ~cur_eop_q & buf_full_q));
    raw_bit   = 1'b1;
    case (state_q)
      S_SYNC:  raw_bit = sync_last;
      S_DATA:  raw_bit = stuff_now ? 1'b0 : shift_q[0];
      default: raw_bit = 1'b1;
    endcase
    // NRZI: a raw 0 flips J<->K, a raw 1 holds the current level.
    line_d = raw_bit ? line_j_q : ~line_j_q;
  end

`ifdef USB_TX_BIT_STUFF_EN
  logic [2:0] ones_q;
  logic [2:0] ones_inc;

  assign ones_inc         = shift_q[0] ? (ones_q + 3'd1) : 3'd0;
  assign stuff_now        = (ones_q == 3'd6);
  assign stuff_after_last = (ones_inc == 3'd6);

  // Runs are counted over data bits only; the SYNC pattern never stuffs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ones_q <= 3'd0;
    end else if (start || (bit_en && (state_q == S_SYNC))) begin
      ones_q <= 3'd0;
    end else if (bit_en && (state_q == S_DATA)) begin
      ones_q <= stuff_now ? 3'd0 : ones_inc;
    end
  end
`else
  assign stuff_now        = 1'b0;
  assign stuff_after_last = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_full_q <= 1'b0;
      buf_data_q <= 8'h00;
      buf_sop_q  <= 1'b0;
      buf_eop_q  <= 1'b0;
    end else if (keep_byte) begin
      buf_full_q <= 1'b1;
      buf_data_q <= tx_to_data;
      buf_sop_q  <= tx_to_sop;
      buf_eop_q  <= tx_to_eop;
    end else if (load || idle_drop) begin
      buf_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= 8'h00;
      cur_eop_q  <= 1'b0;
      bit_cnt_q  <= 3'd0;
      line_j_q   <= 1'b1;
      done_q     <= 1'b0;
      dp_q       <= 1'b1;
      dn_q       <= 1'b0;
      oe_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bit_en) begin
            dp_q <= 1'b1;
            dn_q <= 1'b0;
            oe_q <= 1'b0;
          end
          if (start) begin
            state_q   <= S_SYNC;
            bit_cnt_q <= 3'd0;
            line_j_q  <= 1'b1;
          end
        end

        S_SYNC: begin
          if (bit_en) begin
            line_j_q  <= line_d;
            dp_q      <= line_d;
            dn_q      <= ~line_d;
            oe_q      <= 1'b1;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (sync_last) begin
              state_q   <= S_DATA;
              shift_q   <= buf_data_q;
              cur_eop_q <= buf_eop_q;
              done_q    <= 1'b0;
            end
          end
        end

        S_DATA: begin
          if (bit_en) begin
            line_j_q <= line_d;
            dp_q     <= line_d;
            dn_q     <= ~line_d;
            oe_q     <= 1'b1;
            if (stuff_now) begin
              // Stuffed zero: no data bit consumed; may be the tail of the packet.
              if (done_q) begin
                state_q   <= S_EOP_SE0;
                bit_cnt_q <= 3'd0;
              end
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (byte_end) begin
                if (cur_eop_q) begin
                  if (stuff_after_last) begin
                    done_q <= 1'b1;
                  end else begin
                    state_q   <= S_EOP_SE0;
                    bit_cnt_q <= 3'd0;
                  end
                end else if (buf_full_q) begin
                  shift_q   <= buf_data_q;
                  cur_eop_q <= buf_eop_q;
                end else begin
                  underrun_q <= 1'b1;
                  state_q    <= S_EOP_SE0;
                  bit_cnt_q  <= 3'd0;
                end
              end
            end
          end
        end

        S_EOP_SE0: begin
          if (bit_en) begin
            dp_q      <= 1'b0;
            dn_q      <= 1'b0;
            oe_q      <= 1'b1;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd1) begin
              state_q <= S_EOP_J;
            end
          end
        end

        S_EOP_J: begin
          if (bit_en) begin
            dp_q     <= 1'b1;
            dn_q     <= 1'b0;
            oe_q     <= 1'b1;
            line_j_q <= 1'b1;
            state_q  <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_to_ready = ~buf_full_q;
  assign usb_dp      = dp_q;
  assign usb_dn      = dn_q;
  assign usb_oe      = oe_q;
  assign tx_busy     = (state_q != S_IDLE);
  assign tx_underrun = underrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer: queue-based line scoreboard fed by a packet-level model.
module tb_usb_tx_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_en = 1'b0;
  logic [7:0] tx_to_data = 8'h00;
  logic       tx_to_sop = 1'b0;
  logic       tx_to_eop = 1'b0;
  logic       tx_to_valid = 1'b0;
  logic       tx_to_ready;
  logic       usb_dp;
  logic       usb_dn;
  logic       usb_oe;
  logic       tx_busy;
  logic       tx_underrun;
  logic [2:0] dbg_state;

  usb_tx_serializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_en      (bit_en),
    .tx_to_data  (tx_to_data),
    .tx_to_sop   (tx_to_sop),
    .tx_to_eop   (tx_to_eop),
    .tx_to_valid (tx_to_valid),
    .tx_to_ready (tx_to_ready),
    .usb_dp      (usb_dp),
    .usb_dn      (usb_dn),
    .usb_oe      (usb_oe),
    .tx_busy     (tx_busy),
    .tx_underrun (tx_underrun),
    .dbg_state_o (dbg_state)
  );

`ifdef USB_TX_BIT_STUFF_EN
  localparam bit STUFF_EN = 1'b1;
`else
  localparam bit STUFF_EN = 1'b0;
`endif

  // Clock and bit strobe (one bit time = 4 clocks)
  always #5 clk = ~clk;

  int be_cnt = 0;
  logic be_seen = 1'b0;
  always @(negedge clk) begin
    be_cnt = (be_cnt + 1) % 4;
    bit_en = (be_cnt == 0);
  end
  always @(posedge clk) be_seen <= bit_en;

  // Scoreboard state
  int n_checks = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];
  bit mon_en = 1'b0;
  int under_cnt = 0;
  int exp_under = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet model: SYNC + LSB-first data with stuffing, NRZI from J, then SE0 SE0 J.
  function automatic void model_packet(input logic [7:0] pkt[$], input bit eop_end);
    bit raw[$];
    int ones;
    bit line_j;
    logic [7:0] bv;
    bit last;
    for (int i = 0; i < 7; i++) raw.push_back(1'b0);
    raw.push_back(1'b1);
    ones = 0;
    for (int i = 0; i < pkt.size(); i++) begin
      bv = pkt[i];
      for (int k = 0; k < 8; k++) begin
        raw.push_back(bv[k]);
        ones = bv[k] ? ones + 1 : 0;
        last = (i == pkt.size() - 1) && (k == 7);
        if (STUFF_EN && ones == 6 && (eop_end || !last)) begin
          raw.push_back(1'b0);
          ones = 0;
        end
      end
    end
    line_j = 1'b1;
    foreach (raw[j]) begin
      if (!raw[j]) line_j = !line_j;
      exp_q.push_back(line_j ? 2'b10 : 2'b01);
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endfunction

  // Monitor: one line symbol per bit time while the driver is enabled.
  always @(negedge clk) begin
    if (mon_en && be_seen) begin
      if (usb_oe) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL line_extra: actual dp=%0b dn=%0b required no driven bit at %0t",
                   usb_dp, usb_dn, $time);
        end else begin
          check("line", {30'd0, usb_dp, usb_dn}, {30'd0, exp_q.pop_front()});
        end
      end else begin
        check("idle_j", {30'd0, usb_dp, usb_dn}, 32'd2);
      end
    end
  end

  always @(negedge clk) if (rst_n && tx_underrun === 1'b1) under_cnt++;

  // Driver tasks
  task automatic push_byte(input logic [7:0] d, input bit sop, input bit eop);
    int n;
    @(negedge clk);
    tx_to_valid = 1'b1;
    tx_to_data  = d;
    tx_to_sop   = sop;
    tx_to_eop   = eop;
    n = 0;
    while (!tx_to_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: actual ready=0 required ready=1 within 2000 clks");
    end
    @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    tx_to_valid = 1'b0;
    tx_to_sop   = 1'b0;
    tx_to_eop   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: actual busy=%0b left=%0d required idle", name, tx_busy, exp_q.size());
    end
    repeat (12) @(negedge clk);
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_underrun"}, under_cnt, exp_under);
    check({name, "_oe_off"}, usb_oe, 1'b0);
  endtask

  task automatic send_packet(input string name, input logic [7:0] pkt[$], input bit eop_end);
    model_packet(pkt, eop_end);
    if (!eop_end) exp_under++;
    for (int i = 0; i < pkt.size(); i++) begin
      push_byte(pkt[i], i == 0, eop_end && (i == pkt.size() - 1));
    end
    drop_valid();
    wait_idle(name);
  endtask

  initial begin
    logic [7:0] pkt[$];
    int len;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_dp", usb_dp, 1'b1);
    check("rst_dn", usb_dn, 1'b0);
    check("rst_oe", usb_oe, 1'b0);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_ready", tx_to_ready, 1'b1);
    check("rst_underrun", tx_underrun, 1'b0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (8) @(negedge clk);

    // Single 0xFF, sop+eop
    pkt = '{8'hFF};
    send_packet("ff", pkt, 1'b1);

    // Token bytes back-to-back
    pkt = '{8'h69, 8'h82, 8'h28};
    send_packet("token", pkt, 1'b1);

    // Underrun: sop byte with nothing following
    pkt = '{8'hA5};
    send_packet("underrun", pkt, 1'b0);

    // Non-sop byte in IDLE is accepted and discarded
    push_byte(8'h3C, 1'b0, 1'b0);
    drop_valid();
    for (int i = 0; i < 10; i++) begin
      repeat (4) @(negedge clk);
      check("nosop_busy", tx_busy, 1'b0);
    end
    check("nosop_ready", tx_to_ready, 1'b1);
    check("nosop_oe", usb_oe, 1'b0);

    // Reset in the middle of DATA
    mon_en = 1'b0;
    push_byte(8'h00, 1'b1, 1'b0);
    drop_valid();
    repeat (48) @(negedge clk);
    check("pre_rst_busy", tx_busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_dp", usb_dp, 1'b1);
    check("mid_rst_dn", usb_dn, 1'b0);
    check("mid_rst_oe", usb_oe, 1'b0);
    check("mid_rst_busy", tx_busy, 1'b0);
    check("mid_rst_ready", tx_to_ready, 1'b1);
    exp_q.delete();
    repeat (8) @(negedge clk);
    mon_en = 1'b1;

    pkt = '{8'hC3, 8'h7E};
    send_packet("post_rst", pkt, 1'b1);

    // Random packets, biased toward long runs of ones
    for (int p = 0; p < 20; p++) begin
      pkt.delete();
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0:       pkt.push_back(8'hFF);
          1:       pkt.push_back(8'hFC | 8'($urandom_range(0, 3)));
          default: pkt.push_back(8'($urandom));
        endcase
      end
      send_packet("rand", pkt, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_tx_serializer.md
USB_TX_SERIALIZER -- requirements
Module: usb_tx_serializer

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all logic rising-edge.
REQ-002 SHALL provide: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL provide: bit_en  input  1  one-clk strobe per USB bit time; line outputs change only on cycles with bit_en=1.
REQ-004 SHALL provide: tx_to_data  input  8  packet byte from token/CRC stage, transmitted LSB first.
REQ-005 SHALL provide: tx_to_sop / tx_to_eop / tx_to_valid  input  1 each  first byte / last byte / byte valid.
REQ-006 SHALL provide: tx_to_ready  output  1  high when the one-entry byte buffer is empty.
REQ-007 SHALL provide: usb_dp, usb_dn, usb_oe  output  1 each  line levels and driver enable.
REQ-008 SHALL provide: tx_busy  output  1  high in any state other than IDLE.
REQ-009 SHALL provide: tx_underrun  output  1  one-clk pulse on buffer underrun.

Function
REQ-010 Byte accepted on any clk edge with tx_to_valid=1 and tx_to_ready=1; held in the buffer with its eop flag.
REQ-011 States: IDLE, SYNC, DATA, EOP_SE0, EOP_J.
REQ-012 IDLE: a non-sop byte is accepted and discarded; a sop byte is buffered and the state moves to SYNC on the same edge.
REQ-013 SYNC: 8 bit times send raw bits 0,0,0,0,0,0,0,1 (0x80 LSB first), then DATA.
REQ-014 DATA: at each byte boundary the shift register loads from the buffer, freeing it; sop on a byte accepted outside IDLE is ignored.
REQ-015 If the buffer is empty at a byte boundary and the last loaded byte had no eop: tx_underrun pulses, state goes to EOP_SE0.
REQ-016 After the last bit of the eop byte (plus any pending stuff bit): EOP_SE0 for 2 bit times (dp=0, dn=0), EOP_J for 1 bit time (dp=1, dn=0), then IDLE with usb_oe=0.
REQ-017 NRZI from SYNC through DATA: raw 0 toggles the line (J<->K), raw 1 holds; J = dp1/dn0, K = dp0/dn1; line starts at J on entering SYNC.
REQ-018 Ones counter clears on entering SYNC and on every transmitted 0 (data or stuffed), increments on each transmitted 1.
REQ-019 When the ones counter reaches 6, the next bit time sends a stuffed 0 without consuming a data bit; this also applies after the final data bit, before EOP.
REQ-020 usb_oe=1 from the first SYNC bit through the EOP_J bit; idle line is dp=1, dn=0, oe=0.
REQ-021 tx_to_ready is low while the buffer is full; a load and an accept in the same cycle are both honoured (buffer stays full).
REQ-022 Throughput: back-to-back bytes with no gap, provided each byte arrives before its predecessor's last bit.

Reset
REQ-023 rst_n=0 at a clk edge: state IDLE, buffer empty, ones counter 0, tx_to_ready=1, tx_busy=0, tx_underrun=0, usb_dp=1, usb_dn=0, usb_oe=0.
REQ-024 Reset mid-packet drops the packet immediately with no EOP; the first post-reset byte is treated per REQ-012.

Configuration
REQ-025 Macro USB_TX_BIT_STUFF_EN: when defined, stuffing per REQ-018/019 is active.
REQ-026 Macro not defined: no stuff bits are ever inserted; the ones counter is absent; all other behaviour is unchanged (PHY loopback/test builds).

Verification
REQ-027 Single byte 0xFF, sop+eop, macro on -> SYNC, six 1s, stuffed 0, two 1s, SE0, SE0, J: 20 bit times with oe=1.
REQ-028 Same stimulus, macro off -> SYNC, eight 1s, EOP: 19 bit times; line held at K for all eight data bits.
REQ-029 Token 0x69, 0x82, 0x28 (sop on first, eop on last), fed back-to-back -> 8+24 data-phase bit times, no stuff bits, tx_to_ready drops only while the buffer is full, tx_underrun=0.
REQ-030 sop byte 0xA5 with no second byte and no eop -> tx_underrun pulses once after bit 8, then SE0, SE0, J, IDLE.
REQ-031 Non-sop byte 0x3C offered in IDLE -> accepted (ready=1), line stays J, oe=0, tx_busy=0.
REQ-032 rst_n low for one clk in mid-DATA -> next edge shows dp=1, dn=0, oe=0, tx_busy=0, tx_to_ready=1.
